// File: rtl/mips_cache_wbuf_coalesce.sv
// Store write buffer sitting between the CPU/cache and an Avalon-MM master port.
// Stores are queued in a circular FIFO and drained in order as Avalon writes.
// A store to the same word as the newest entry merges into that entry, unless
// that entry is the head currently being presented on the bus. Loads snoop the
// buffer through a combinational byte-forwarding lookup.
module mips_cache_wbuf_coalesce #(
  parameter int DEPTH_BITS = 3,
  parameter int COALESCE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_write,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_writedata,
  input  logic [3:0]            in_byteenable,
  output logic                  in_stall,
  output logic [31:0]           avm_address,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           lookup_addr,
  output logic                  lookup_hit,
  output logic [31:0]           lookup_data,
  output logic [3:0]            lookup_byteenable,
  output logic [DEPTH_BITS:0]   count,
  output logic                  empty
);

  localparam int                    DEPTH      = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   CNT_ONE    = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);

  // Expand 4 lane enables into a 32-bit byte mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Entry storage; contents are only meaningful inside [head, head+count).
  logic [29:0]           addr_r [DEPTH];
  logic [31:0]           data_r [DEPTH];
  logic [3:0]            be_r   [DEPTH];

  logic [DEPTH_BITS-1:0] head_r;
  logic [DEPTH_BITS-1:0] tail_r;
  logic [DEPTH_BITS:0]   count_r;

  logic [DEPTH_BITS-1:0] newest_s;
  logic                  busy_s;
  logic                  coalesce_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  merge_s;
  logic                  pop_s;
  logic [31:0]           merged_data_s;
  logic                  unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^{in_addr[1:0], lookup_addr[1:0]};

  assign busy_s   = (count_r != {(DEPTH_BITS + 1){1'b0}});
  assign newest_s = tail_r - PTR_ONE;

  // Accept/merge/pop decisions for the current cycle. When busy the head is
  // always on the bus, so a single-entry buffer never merges.
  always_comb begin
    coalesce_s = 1'b0;
    if ((COALESCE != 0) && busy_s && (addr_r[newest_s] == in_addr[31:2])) begin
      coalesce_s = !((newest_s == head_r) && busy_s);
    end else begin
      coalesce_s = 1'b0;
    end
    in_stall = in_write && (count_r == FULL_COUNT) && !coalesce_s;
    accept_s = in_write && !in_stall && (in_byteenable != 4'h0);
    push_s   = accept_s && !coalesce_s;
    merge_s  = accept_s && coalesce_s;
    pop_s    = busy_s && !avm_waitrequest;
  end

  // Lane-wise overwrite of the newest entry's data by an incoming store.
  always_comb begin
    merged_data_s = data_r[newest_s];
    for (int l = 0; l < 4; l++) begin
      merged_data_s[8*l +: 8] = in_byteenable[l] ? in_writedata[8*l +: 8]
                                                 : data_r[newest_s][8*l +: 8];
    end
  end

  // Pointer and occupancy state; the only state that reset has to clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {DEPTH_BITS{1'b0}};
      tail_r  <= {DEPTH_BITS{1'b0}};
      count_r <= {(DEPTH_BITS + 1){1'b0}};
    end else begin
      head_r <= pop_s  ? head_r + PTR_ONE : head_r;
      tail_r <= push_s ? tail_r + PTR_ONE : tail_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload writes: new entries at the tail, merges into the newest.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_r[tail_r] <= in_addr[31:2];
      data_r[tail_r] <= in_writedata & lane_mask(in_byteenable);
      be_r[tail_r]   <= in_byteenable;
    end else if (merge_s) begin
      data_r[newest_s] <= merged_data_s;
      be_r[newest_s]   <= be_r[newest_s] | in_byteenable;
    end
  end

  // Avalon side shows the head entry, straight from registers; zero when empty
  // so stale entry contents never leak out.
  always_comb begin
    avm_write = busy_s;
    if (busy_s) begin
      avm_address    = {addr_r[head_r], 2'b00};
      avm_writedata  = data_r[head_r];
      avm_byteenable = be_r[head_r];
    end else begin
      avm_address    = 32'h0000_0000;
      avm_writedata  = 32'h0000_0000;
      avm_byteenable = 4'h0;
    end
  end

  // Load forwarding: walk entries oldest to newest so newer lanes win.
  always_comb begin : lookup_comb
    logic [DEPTH_BITS-1:0] idx_v;
    logic                  match_v;
    idx_v             = head_r;
    match_v           = 1'b0;
    lookup_data       = 32'h0000_0000;
    lookup_byteenable = 4'h0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v   = head_r + DEPTH_BITS'(k);
      match_v = ((DEPTH_BITS + 1)'(k) < count_r) && (addr_r[idx_v] == lookup_addr[31:2]);
      for (int l = 0; l < 4; l++) begin
        lookup_data[8*l +: 8] = (match_v && be_r[idx_v][l]) ? data_r[idx_v][8*l +: 8]
                                                            : lookup_data[8*l +: 8];
        lookup_byteenable[l]  = (match_v && be_r[idx_v][l]) ? 1'b1 : lookup_byteenable[l];
      end
    end
    lookup_hit = |lookup_byteenable;
  end

  assign count = count_r;
  assign empty = !busy_s;

endmodule

// File: tb/tb_mips_cache_wbuf_coalesce.sv
// Bench for mips_cache_wbuf_coalesce: two instances (merging on / off) share the
// same stimulus. A queue-based model predicts every cycle's observable state;
// each predicted Avalon write is pushed into a scoreboard that a separate
// monitor drains whenever a DUT completes a bus write.
module tb_mips_cache_wbuf_coalesce;
  localparam int DB    = 3;
  localparam int DEPTH = 1 << DB;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_write;
  logic [31:0] in_addr, in_writedata, lookup_addr;
  logic [3:0] in_byteenable;
  logic avm_waitrequest;

  logic [1:0]       in_stall_w, avm_write_w, lookup_hit_w, empty_w;
  logic [1:0][31:0] avm_address_w, avm_writedata_w, lookup_data_w;
  logic [1:0][3:0]  avm_byteenable_w, lookup_be_w, count_w;

  entry_t mq    [2][$];
  entry_t exp_q [2][$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_cache_wbuf_coalesce #(.DEPTH_BITS(DB), .COALESCE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_write(in_write), .in_addr(in_addr),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable), .in_stall(in_stall_w[0]),
    .avm_address(avm_address_w[0]), .avm_write(avm_write_w[0]), .avm_writedata(avm_writedata_w[0]),
    .avm_byteenable(avm_byteenable_w[0]), .avm_waitrequest(avm_waitrequest),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit_w[0]), .lookup_data(lookup_data_w[0]),
    .lookup_byteenable(lookup_be_w[0]), .count(count_w[0]), .empty(empty_w[0]));

  mips_cache_wbuf_coalesce #(.DEPTH_BITS(DB), .COALESCE(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_write(in_write), .in_addr(in_addr),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable), .in_stall(in_stall_w[1]),
    .avm_address(avm_address_w[1]), .avm_write(avm_write_w[1]), .avm_writedata(avm_writedata_w[1]),
    .avm_byteenable(avm_byteenable_w[1]), .avm_waitrequest(avm_waitrequest),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit_w[1]), .lookup_data(lookup_data_w[1]),
    .lookup_byteenable(lookup_be_w[1]), .count(count_w[1]), .empty(empty_w[1]));

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Monitor: every completed bus write must match the next predicted one.
  always @(negedge clk) begin
    entry_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && avm_write_w[i] && !avm_waitrequest) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_write[%0d]", i), 32'd1, 32'd0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("avm_address[%0d]", i), avm_address_w[i], {e.wa, 2'b00});
          check($sformatf("avm_byteenable[%0d]", i), 32'(avm_byteenable_w[i]), 32'(e.be));
          check($sformatf("avm_writedata[%0d]", i), avm_writedata_w[i] & lane_mask(e.be), e.data);
        end
      end
    end
  end

  // One clock cycle: apply inputs, predict, compare at negedge, advance model.
  task automatic cycle(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit wr, input logic [31:0] la);
    bit          e_stall [2];
    bit          e_avm   [2];
    int          e_cnt   [2];
    logic [3:0]  e_lbe   [2];
    logic [31:0] e_ldata [2];
    bit coal, pop, acc;
    int n;
    entry_t e;
    in_write = w; in_addr = a; in_writedata = d; in_byteenable = be;
    avm_waitrequest = wr; lookup_addr = la;
    for (int i = 0; i < 2; i++) begin
      n = mq[i].size();
      e_cnt[i] = n;
      e_avm[i] = (n > 0);
      coal = (i == 0) && (n > 0) && (mq[i][n-1].wa == a[31:2]) && !(n == 1 && e_avm[i]);
      e_stall[i] = w && (n == DEPTH) && !coal;
      acc = w && !e_stall[i] && (be != 4'h0);
      pop = e_avm[i] && !wr;
      e_lbe[i] = 4'h0; e_ldata[i] = 32'h0;
      for (int k = 0; k < n; k++) begin
        if (mq[i][k].wa == la[31:2]) begin
          for (int l = 0; l < 4; l++) begin
            if (mq[i][k].be[l]) begin
              e_lbe[i][l] = 1'b1;
              e_ldata[i][8*l +: 8] = mq[i][k].data[8*l +: 8];
            end
          end
        end
      end
      if (acc && coal) begin
        e = mq[i][n-1];
        e.data = (e.data & ~lane_mask(be)) | (d & lane_mask(be));
        e.be = e.be | be;
        mq[i][n-1] = e;
      end
      if (pop) exp_q[i].push_back(mq[i].pop_front());
      if (acc && !coal) begin
        e.wa = a[31:2]; e.data = d & lane_mask(be); e.be = be;
        mq[i].push_back(e);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_stall[%0d]", i), 32'(in_stall_w[i]), 32'(e_stall[i]));
      check($sformatf("avm_write[%0d]", i), 32'(avm_write_w[i]), 32'(e_avm[i]));
      check($sformatf("count[%0d]", i), 32'(count_w[i]), 32'(e_cnt[i]));
      check($sformatf("empty[%0d]", i), 32'(empty_w[i]), 32'(e_cnt[i] == 0));
      check($sformatf("lookup_be[%0d]", i), 32'(lookup_be_w[i]), 32'(e_lbe[i]));
      check($sformatf("lookup_hit[%0d]", i), 32'(lookup_hit_w[i]), 32'(e_lbe[i] != 4'h0));
      check($sformatf("lookup_data[%0d]", i), lookup_data_w[i], e_ldata[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_write = 1'b0; in_byteenable = 4'h0; avm_waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      exp_q[i].delete();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_avm_write[%0d]", i), 32'(avm_write_w[i]), 32'd0);
      check($sformatf("rst_count[%0d]", i), 32'(count_w[i]), 32'd0);
      check($sformatf("rst_empty[%0d]", i), 32'(empty_w[i]), 32'd1);
      check($sformatf("rst_lookup_be[%0d]", i), 32'(lookup_be_w[i]), 32'd0);
      check($sformatf("rst_in_stall[%0d]", i), 32'(in_stall_w[i]), 32'd0);
    end
  endtask

  task automatic idle(input bit wr, input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 32'h0, 32'h0, 4'h0, wr, 32'h0);
  endtask

  initial begin
    in_write = 1'b0; in_addr = 32'h0; in_writedata = 32'h0; in_byteenable = 4'h0;
    avm_waitrequest = 1'b0; lookup_addr = 32'h0; rst_n = 1'b0;
    do_reset();

    // Single store then drain.
    cycle(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0, 32'h100);
    check("drain_addr", avm_address_w[0], 32'h100);
    check("drain_data", avm_writedata_w[0], 32'hAABBCCDD);
    check("drain_be", 32'(avm_byteenable_w[0]), 32'hF);
    idle(1'b0, 1);
    check("drain_empty", 32'(empty_w[0]), 32'd1);

    // Coalesce behind a stalled head.
    do_reset();
    cycle(1'b1, 32'h500, 32'h01020304, 4'hF, 1'b1, 32'h0);
    cycle(1'b1, 32'h204, 32'h00001122, 4'h3, 1'b1, 32'h0);
    cycle(1'b1, 32'h206, 32'h33440000, 4'hC, 1'b1, 32'h0);
    check("coal_count", 32'(count_w[0]), 32'd2);
    idle(1'b0, 1);
    check("coal_addr", avm_address_w[0], 32'h204);
    check("coal_data", avm_writedata_w[0], 32'h33441122);
    check("coal_be", 32'(avm_byteenable_w[0]), 32'hF);
    idle(1'b0, 2);

    // Full / stall, with pointers pre-advanced so the queue wraps.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h5F0 + 32'(4*k), 32'h0, 4'hF, 1'b1, 32'h0);
    idle(1'b0, 3);
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h600 + 32'(4*k), $urandom, 4'hF, 1'b1, 32'h0);
    check("full_count", 32'(count_w[0]), 32'd8);
    cycle(1'b1, 32'h700, 32'h12345678, 4'hF, 1'b1, 32'h0);
    check("full_stall", 32'(in_stall_w[0]), 32'd1);
    cycle(1'b1, 32'h61C, 32'hCAFE0000, 4'hC, 1'b1, 32'h0);
    check("full_merge_nostall", 32'(in_stall_w[0]), 32'd0);
    check("full_nc_stall", 32'(in_stall_w[1]), 32'd1);
    idle(1'b0, 10);

    // Forwarding from two uncoalesced entries of one word.
    do_reset();
    cycle(1'b1, 32'h300, 32'h11111111, 4'hF, 1'b1, 32'h0);
    cycle(1'b1, 32'h302, 32'h0000AB00, 4'h2, 1'b1, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h302);
    check("fwd_hit", 32'(lookup_hit_w[0]), 32'd1);
    check("fwd_be", 32'(lookup_be_w[0]), 32'hF);
    check("fwd_data", lookup_data_w[0], 32'h1111AB11);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h304);
    check("fwd_miss_hit", 32'(lookup_hit_w[0]), 32'd0);
    check("fwd_miss_data", lookup_data_w[0], 32'h0);

    // Reset during a stalled transfer, then normal traffic.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h880 + 32'(4*k), $urandom, 4'hF, 1'b1, 32'h0);
    do_reset();
    cycle(1'b1, 32'h800, 32'hDEADBEEF, 4'hF, 1'b0, 32'h800);
    idle(1'b0, 2);

    // Same-word stores behind a head entry: merged vs. separate writes.
    do_reset();
    cycle(1'b1, 32'h880, 32'h0, 4'hF, 1'b1, 32'h0);
    cycle(1'b1, 32'h900, 32'h000000AA, 4'h1, 1'b1, 32'h0);
    cycle(1'b1, 32'h900, 32'h0000BB00, 4'h2, 1'b1, 32'h0);
    check("nc_count", 32'(count_w[1]), 32'd3);
    check("c_count", 32'(count_w[0]), 32'd2);
    idle(1'b0, 4);

    // Randomized traffic over a small address pool to force hits and merges.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle(($urandom % 4) != 0, 32'h1000 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4),
            $urandom, 4'($urandom % 16), ($urandom % 3) != 0,
            32'h1000 + 32'(4 * ($urandom % 5)));
    end
    idle(1'b0, DEPTH + 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("scoreboard_drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cache_wbuf_coalesce.md
MIPS_CACHE_WBUF_COALESCE -- requirements
Module: mips_cache_wbuf_coalesce

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH_BITS, 3: log2 of entry count; DEPTH = 2**DEPTH_BITS.
- COALESCE, 1: 1 enables merging a write into the newest entry; 0 disables merging.
REQ-002 Address and data SHALL be fixed at 32 bits, with 4 byte lanes.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the only clock; all state changes on its rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- in_write, in, 1: CPU/cache store request.
- in_addr, in, 32: store byte address; bits [1:0] ignored.
- in_writedata, in, 32: store data.
- in_byteenable, in, 4: store lane enables.
- in_stall, out, 1: store not accepted this cycle.
- avm_address, out, 32: Avalon write address, word-aligned.
- avm_write, out, 1: Avalon write request.
- avm_writedata, out, 32: Avalon write data.
- avm_byteenable, out, 4: Avalon lane enables.
- avm_waitrequest, in, 1: Avalon slave stall.
- lookup_addr, in, 32: load address to snoop.
- lookup_hit, out, 1: some buffered byte matches lookup_addr's word.
- lookup_data, out, 32: forwarded bytes.
- lookup_byteenable, out, 4: lanes of lookup_data that are valid.
- count, out, DEPTH_BITS+1: number of valid entries.
- empty, out, 1: count == 0.

Function
REQ-004 The buffer SHALL be a circular FIFO of DEPTH entries, each holding {word address [31:2], data[31:0], be[3:0]}, with head/tail pointers that wrap modulo DEPTH.
REQ-005 A store SHALL be accepted on a cycle where in_write=1 and in_stall=0.
REQ-006 A store with in_byteenable=0 SHALL be accepted and discarded: no entry created, no state change.
REQ-007 Coalesce condition: COALESCE=1, count>0, the newest entry has the same word address as in_addr, and the newest entry is not the head while avm_write=1.
REQ-008 An accepted store meeting the coalesce condition SHALL merge into the newest entry: each lane with in_byteenable=1 overwrites data, the entry's be becomes the OR of old and new, and count is unchanged.
REQ-009 An accepted store not meeting the coalesce condition SHALL be written at the tail, incrementing the tail pointer and count.
REQ-010 in_stall SHALL equal in_write AND count==DEPTH AND NOT coalesce-condition; it is combinational.
REQ-011 A pop in the same cycle SHALL NOT unstall a full buffer.
REQ-012 avm_write SHALL equal NOT empty, derived from registered state.
REQ-013 avm_address SHALL be {head word address, 2'b00}; avm_writedata and avm_byteenable SHALL show the head entry.
REQ-014 The head entry SHALL be popped when avm_write=1 and avm_waitrequest=0.
REQ-015 While avm_write=1 and avm_waitrequest=1, all avm_* outputs SHALL be held stable; the head entry is never modified.
REQ-016 A simultaneous accepted push and pop SHALL leave count unchanged.
REQ-017 A simultaneous accepted coalesce and pop SHALL decrement count by 1.
REQ-018 Latency: a store accepted into an empty buffer SHALL appear on avm_write on the next cycle; there is no combinational path from in_* to avm_*.
REQ-019 Lookup SHALL be combinational over all valid entries whose word address equals lookup_addr[31:2].
REQ-020 Lookup outputs: lookup_byteenable is the OR of the matching entries' be; each lane of lookup_data comes from the newest matching entry with that lane enabled; lookup_hit = |lookup_byteenable.
REQ-021 Lanes without a match SHALL read 0.
REQ-022 Lookup SHALL reflect registered state only; a store accepted in the same cycle is not visible.
REQ-023 count and empty SHALL be registered-state outputs, consistent with the pointers in every cycle.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL clear head, tail and count, and invalidate all entries.
REQ-025 After that reset edge, avm_write=0, empty=1, count=0, lookup_hit=0, lookup_byteenable=0, and in_stall=0.
REQ-026 Reset during an Avalon transfer (avm_waitrequest=1) SHALL abandon the transfer: avm_write=0 on the cycle after the reset edge, and buffered stores are lost.
REQ-027 Entry data/address contents need not be cleared by reset, but SHALL NOT be observable while invalid.

Verification
REQ-028 Single store then drain: store addr=0x100, data=0xAABBCCDD, be=4'hF, with avm_waitrequest=0 -> the next cycle shows avm_write=1, addr=0x100, data=0xAABBCCDD, be=F; the cycle after that shows empty=1.
REQ-029 Coalesce: hold avm_waitrequest=1 with one different-address head entry queued; store 0x204/be=4'h3/data=0x00001122, then 0x206/be=4'hC/data=0x33440000 -> count=2, and the second entry later drains as addr 0x204, data 0x33441122, be=F.
REQ-030 Full/stall: DEPTH_BITS=3, avm_waitrequest=1, then 8 distinct-word stores -> count=8; a 9th distinct store gives in_stall=1; a 9th store to the newest word merges with in_stall=0; drop waitrequest -> 8 pops in address order, with wrap-around verified.
REQ-031 Forwarding: entries 0x300 (be=F, data=0x11111111) and 0x300 (be=2, data=0x0000AB00) with coalescing blocked -> lookup 0x302 gives hit=1, be=F, data=0x1111AB11; lookup 0x304 gives hit=0, be=0, data=0.
REQ-032 Reset mid-transfer: 3 entries queued, avm_waitrequest=1, assert rst_n=0 for one edge -> the next cycle shows avm_write=0, count=0, empty=1; a subsequent store drains normally.
REQ-033 COALESCE=0: two stores to the same word -> count=2, and two separate Avalon writes in order.
